data_memory_ctrl: RTL

//  Parametrised data memory with a valid/ready request port, a configurable

---
 rtl/data_mem_if.sv | 25 ++
 rtl/data_memory_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Request/response bundle between the load-store unit and the data memory controller.
// The master drives requests; the slave (the controller) returns a single response pulse.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with wait states, byte-lane stores and extended loads.
// One request in flight; faulting requests skip the wait phase and never touch memory.
module data_memory_ctrl #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  data_mem_if.slave  mem_if
);

  // state    | meaning
  // ST_IDLE  | ready, waiting for a request
  // ST_WAIT  | counting wait states of a legal request
  // ST_RESP  | one-cycle response pulse
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int AW = $clog2(DEPTH);
  localparam int WL = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
  localparam logic [3:0] WAIT_LOAD = 4'(WL);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [1:0]      lane_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            err_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            rsp_err_q;

  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            enter_resp;
  logic [31:0]     off;
  logic            in_range;
  logic            align_ok;
  logic            req_err;

  logic            acc_we;
  logic            acc_uns;
  logic [1:0]      acc_size;
  logic [1:0]      acc_lane;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic            acc_err;

  logic [31:0]     cur_word;
  logic [31:0]     shifted;
  logic [31:0]     wmask;
  logic [31:0]     wval;

  assign accept = mem_if.req_valid && (state_q == ST_IDLE);

  // Request decode on the live inputs; only meaningful in the accept cycle.
  assign off      = mem_if.req_addr - BASE_ADDR;
  assign in_range = (mem_if.req_addr >= BASE_ADDR) && (off[31:AW+2] == '0);

  always_comb begin
    align_ok = 1'b0;
    case (mem_if.req_size)
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~off[0];
      2'b10:   align_ok = (off[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign req_err = ~in_range | ~align_ok;

  // Zero-wait and faulting requests go IDLE->RESP directly, so the access must
  // see the live request rather than the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = mem_if.req_we;
      acc_uns   = mem_if.req_unsigned;
      acc_size  = mem_if.req_size;
      acc_lane  = off[1:0];
      acc_idx   = off[AW+1:2];
      acc_wdata = mem_if.req_wdata;
      acc_err   = req_err;
    end else begin
      acc_we    = we_q;
      acc_uns   = uns_q;
      acc_size  = size_q;
      acc_lane  = lane_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_err   = err_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err || (WAIT_STATES == 0)) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Load path: lane-aligned extraction, then sign/zero extension.
  always_comb begin
    cur_word = mem_q[acc_idx];
    shifted  = cur_word >> {acc_lane, 3'b000};
    rdata_d  = 32'h0;
    if (!acc_we && !acc_err) begin
      case (acc_size)
        2'b00:   rdata_d = acc_uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
        2'b01:   rdata_d = acc_uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        default: rdata_d = cur_word;
      endcase
    end
  end

  // Store path: lane mask and data placed at the addressed lanes.
  always_comb begin
    wmask = 32'h0;
    wval  = 32'h0;
    case (acc_size)
      2'b00: begin
        wmask = 32'h0000_00FF << {acc_lane, 3'b000};
        wval  = {24'h0, acc_wdata[7:0]} << {acc_lane, 3'b000};
      end
      2'b01: begin
        wmask = 32'h0000_FFFF << {acc_lane[1], 4'b0000};
        wval  = {16'h0, acc_wdata[15:0]} << {acc_lane[1], 4'b0000};
      end
      default: begin
        wmask = 32'hFFFF_FFFF;
        wval  = acc_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !acc_err) begin
      mem_q[acc_idx] <= (cur_word & ~wmask) | (wval & wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= mem_if.req_we;
        uns_q   <= mem_if.req_unsigned;
        size_q  <= mem_if.req_size;
        lane_q  <= off[1:0];
        idx_q   <= off[AW+1:2];
        wdata_q <= mem_if.req_wdata;
        err_q   <= req_err;
      end
      if (enter_resp) begin
        rdata_q   <= rdata_d;
        rsp_err_q <= acc_err;
      end else if (state_q == ST_RESP) begin
        rdata_q   <= 32'h0;
        rsp_err_q <= 1'b0;
      end
    end
  end

  assign mem_if.req_ready = (state_q == ST_IDLE);
  assign mem_if.busy      = (state_q != ST_IDLE);
  assign mem_if.rsp_valid = (state_q == ST_RESP);
  assign mem_if.rsp_rdata = rdata_q;
  assign mem_if.rsp_err   = rsp_err_q;

endmodule
